// File: rtl/player_link_rx.sv
// Receiver for the 3-bit player move lines: 2-flop sync, glitch/illegal-code filter, held-move FSM, event strobe.
// Define PLAYER_RX_REPEAT_EN to enable auto-repeat events while a move is held.
module player_link_rx #(
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CNT_W         = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] player_M_in,
  output logic [2:0] move,
  output logic       move_valid,
  output logic [2:0] move_code,
  output logic       repeat_flag,
  output logic       link_err,
  input  logic       err_clr
);

  localparam int FCNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] F_ACC = FCNT_W'(STABLE_CYCLES - 2);
  localparam logic [FCNT_W-1:0] F_SAT = FCNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("player_link_rx: STABLE_CYCLES must be at least 2");
  end
  if ((CNT_W < 1) || (CNT_W > 31) ||
      (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1) ||
      (longint'(REPEAT_DELAY)  > (longint'(1) << CNT_W)) ||
      (longint'(REPEAT_PERIOD) > (longint'(1) << CNT_W))) begin : g_bad_cnt
    $error("player_link_rx: CNT_W too small for repeat timing");
  end

  logic [2:0]        s1, s2;
  logic [2:0]        cand;
  logic [FCNT_W-1:0] fcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 3'd0;
      s2 <= 3'd0;
    end else begin
      s1 <= player_M_in;
      s2 <= s1;
    end
  end

  // Acceptance fires on the edge where fcnt steps onto STABLE_CYCLES-1, so
  // exactly STABLE_CYCLES matching samples are needed; after that fcnt parks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= 3'd0;
      fcnt <= '0;
    end else if (s2 != cand) begin
      cand <= s2;
      fcnt <= '0;
    end else if (fcnt != F_SAT) begin
      fcnt <= fcnt + 1'b1;
    end
  end

  logic accept, acc_bad, acc_new;
  assign accept  = (s2 == cand) && (fcnt == F_ACC);
  assign acc_bad = accept && (cand > 3'd4);
  assign acc_new = accept && (cand <= 3'd4) && (cand != move);

`ifdef PLAYER_RX_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  localparam state_t HOLD = DELAY;
  localparam logic [CNT_W-1:0] T_DELAY  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] T_PERIOD = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rcnt;
  logic [CNT_W-1:0] rterm;
`else
  typedef enum logic {IDLE, HELD} state_t;
  localparam state_t HOLD = HELD;
`endif

  state_t state;

`ifdef PLAYER_RX_REPEAT_EN
  assign rterm = (state == REPEAT) ? T_PERIOD : T_DELAY;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      move        <= 3'd0;
      move_valid  <= 1'b0;
      move_code   <= 3'd0;
      repeat_flag <= 1'b0;
      link_err    <= 1'b0;
`ifdef PLAYER_RX_REPEAT_EN
      rcnt        <= '0;
`endif
    end else begin
      move_valid  <= 1'b0;
      repeat_flag <= 1'b0;
      if (err_clr) link_err <= 1'b0;

      // A stable illegal code drops the held move; set beats a same-cycle clear.
      if (acc_bad) begin
        link_err <= 1'b1;
        move     <= 3'd0;
        state    <= IDLE;
      end else begin
        if (acc_new) move <= cand;
        case (state)
          IDLE: begin
            if (acc_new && (cand != 3'd0)) begin
              move_valid <= 1'b1;
              move_code  <= cand;
              state      <= HOLD;
`ifdef PLAYER_RX_REPEAT_EN
              rcnt       <= '0;
`endif
            end
          end
          default: begin
            if (acc_new) begin
              if (cand == 3'd0) begin
                state <= IDLE;
              end else begin
                // A new code wins over a coinciding repeat terminal count.
                move_valid <= 1'b1;
                move_code  <= cand;
                state      <= HOLD;
`ifdef PLAYER_RX_REPEAT_EN
                rcnt       <= '0;
`endif
              end
            end
`ifdef PLAYER_RX_REPEAT_EN
            else if (rcnt == rterm) begin
              move_valid  <= 1'b1;
              repeat_flag <= 1'b1;
              move_code   <= move;
              rcnt        <= '0;
              state       <= REPEAT;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_link_rx.sv
// Directed bench for player_link_rx: per-cycle vector table plus event-log sequences.
module tb_player_link_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] player_M_in;
  logic [2:0] move;
  logic       move_valid;
  logic [2:0] move_code;
  logic       repeat_flag;
  logic       link_err;
  logic       err_clr;

  player_link_rx #(
    .STABLE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .CNT_W(5)
  ) dut (
    .clk(clk), .rst(rst), .player_M_in(player_M_in), .move(move),
    .move_valid(move_valid), .move_code(move_code), .repeat_flag(repeat_flag),
    .link_err(link_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled mid-cycle.
  int         ev_cyc[$];
  logic [2:0] ev_code[$];
  logic       ev_rf[$];
  always @(negedge clk) begin
    if (move_valid === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_code.push_back(move_code);
      ev_rf.push_back(repeat_flag);
    end
  end

  int         ex_cyc[$];
  logic [2:0] ex_code[$];
  logic       ex_rf[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input int c, input logic [2:0] code, input logic rf);
    ex_cyc.push_back(c);
    ex_code.push_back(code);
    ex_rf.push_back(rf);
  endtask

  task automatic compare_events(input string name);
    int n;
    chk({name, "_count"}, ev_cyc.size(), ex_cyc.size());
    n = (ev_cyc.size() < ex_cyc.size()) ? ev_cyc.size() : ex_cyc.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_ev%0d_cyc", name, i), ev_cyc[i], ex_cyc[i]);
      chk($sformatf("%s_ev%0d_code", name, i), {29'd0, ev_code[i]}, {29'd0, ex_code[i]});
      chk($sformatf("%s_ev%0d_rf", name, i), {31'd0, ev_rf[i]}, {31'd0, ex_rf[i]});
    end
    ev_cyc.delete(); ev_code.delete(); ev_rf.delete();
    ex_cyc.delete(); ex_code.delete(); ex_rf.delete();
  endtask

  typedef struct {
    logic       r;
    logic [2:0] in;
    logic       clr;
    logic [2:0] mv;
    logic       vld;
    logic [2:0] code;
    logic       rf;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [2:0] in, input logic clr,
                              input logic [2:0] mv, input logic vld, input logic [2:0] code,
                              input logic rf, input logic err);
    vec_t v;
    v.r = r; v.in = in; v.clr = clr; v.mv = mv; v.vld = vld; v.code = code; v.rf = rf; v.err = err;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int c, c2;
    rst = 1'b1; player_M_in = 3'd3; err_clr = 1'b0;

    // Reset with 3 held, release, event 6 edges later; then release to 0.
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 0, 3, 1, 3, 0, 0));
    tbl.push_back(mk(0, 3, 0, 3, 0, 3, 0, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 0, (i < 5) ? 3'd3 : 3'd0, 0, 3, 0, 0));
    // 2-cycle glitch of 1: ignored.
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0));
    // 4-cycle pulse of 1: accepted once, then back to 0 without an event.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; player_M_in = tbl[i].in; err_clr = tbl[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d {move,vld,code,rf,err}", i),
          {23'd0, move, move_valid, move_code, repeat_flag, link_err},
          {23'd0, tbl[i].mv, tbl[i].vld, tbl[i].code, tbl[i].rf, tbl[i].err});
    end
    ev_cyc.delete(); ev_code.delete(); ev_rf.delete();

    // Hold 2: first event, then repeats at +20 and every 8 after; release stops them.
    c = cyc;
    player_M_in = 3'd2;
    step(56);
    player_M_in = 3'd0;
    step(40);
    expect_ev(c + 6, 2, 0);
`ifdef PLAYER_RX_REPEAT_EN
    for (int k = 0; k < 5; k++) expect_ev(c + 26 + 8 * k, 2, 1);
`endif
    compare_events("hold2");
    chk("hold2_move_after_release", {29'd0, move}, 32'd0);

    // Hold 1 into REPEAT, switch to 4 so acceptance lands on a repeat terminal count.
    c = cyc;
    player_M_in = 3'd1;
    step(36);
    player_M_in = 3'd4;
    step(27);
    player_M_in = 3'd0;
    step(30);
    expect_ev(c + 6, 1, 0);
`ifdef PLAYER_RX_REPEAT_EN
    expect_ev(c + 26, 1, 1);
    expect_ev(c + 34, 1, 1);
`endif
    expect_ev(c + 42, 4, 0);
`ifdef PLAYER_RX_REPEAT_EN
    expect_ev(c + 62, 4, 1);
`endif
    compare_events("switch");

    // Illegal codes and the sticky error flag.
    c = cyc;
    player_M_in = 3'd1;
    step(10);
    chk("illegal_move_before", {29'd0, move}, 32'd1);
    player_M_in = 3'd6;
    step(5);
    chk("illegal_err_not_yet", {31'd0, link_err}, 32'd0);
    step(1);
    chk("illegal_err_set", {31'd0, link_err}, 32'd1);
    chk("illegal_move_cleared", {29'd0, move}, 32'd0);
    step(2);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("err_clr", {31'd0, link_err}, 32'd0);
    player_M_in = 3'd7;
    step(5);
    chk("err_before_7", {31'd0, link_err}, 32'd0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("err_set_beats_clr", {31'd0, link_err}, 32'd1);
    step(2);
    chk("err_sticky", {31'd0, link_err}, 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("err_clr_after_7", {31'd0, link_err}, 32'd0);
    player_M_in = 3'd0;
    step(10);
    expect_ev(c + 6, 1, 0);
    compare_events("illegal");

    // Reset mid-hold: immediate clear, then one fresh non-repeat event.
    c = cyc;
    player_M_in = 3'd3;
    step(10);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {23'd0, move, move_valid, move_code, repeat_flag, link_err}, 32'd0);
    step(2);
    rst = 1'b0;
    c2 = cyc;
    step(5);
    chk("midrst_move_not_yet", {29'd0, move}, 32'd0);
    step(5);
    chk("midrst_move", {29'd0, move}, 32'd3);
    expect_ev(c + 6, 3, 0);
    expect_ev(c2 + 6, 3, 0);
    compare_events("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
